// File: rtl/firebird7_in_gate1_trim_override_pkg.sv
// Shared types and defaults for the trim-fuse override scan controller.
package firebird7_in_gate1_trim_override_pkg;

    localparam int DATA_W_DEF = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_OPEN_CAP,
        ST_OPEN_SHIFT,
        ST_OPEN_UPD,
        ST_OPEN_WAIT,
        ST_DATA_CAP,
        ST_DATA_SHIFT,
        ST_DATA_UPD,
        ST_DONE
    } state_t;

endpackage

// File: rtl/firebird7_in_gate1_trim_override_shreg.sv
// Parallel-load, MSB-first serial shift register shared by the write and read-back paths.
module firebird7_in_gate1_trim_override_shreg
    import firebird7_in_gate1_trim_override_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              ijtag_tck,
    input  logic              ijtag_reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              shift,
    input  logic              shift_in,
    output logic [DATA_W-1:0] data
);

    // Write data leaves from the MSB while captured scan-out enters at the LSB,
    // so after DATA_W shifts the register holds the old contents in order.
    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end else if (shift) begin
            data <= (data << 1) | DATA_W'(shift_in);
        end
    end

endmodule

// File: rtl/firebird7_in_gate1_trim_override_scan_ctrl.sv
// Opens a SIB, writes the trim override register through it and closes it again in one pass.
module firebird7_in_gate1_trim_override_scan_ctrl
    import firebird7_in_gate1_trim_override_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              ijtag_tck,
    input  logic              ijtag_reset,
    input  logic              req_valid,
    input  logic [DATA_W-1:0] req_data,
    output logic              req_ready,
    output logic              done,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              ijtag_sel,
    output logic              ijtag_ce,
    output logic              ijtag_se,
    output logic              ijtag_ue,
    output logic              ijtag_si,
    input  logic              ijtag_so
);

    localparam int              CNT_W    = $clog2(DATA_W + 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] sr_data;
    logic              sr_load;
    logic              sr_shift;

    assign sr_load  = (state == ST_IDLE) && req_valid;
    // Shift cycle 0 carries the SIB close bit; its scan-out sample is the SIB itself.
    assign sr_shift = (state == ST_DATA_SHIFT) && (cnt != '0);

    firebird7_in_gate1_trim_override_shreg #(
        .DATA_W (DATA_W)
    ) u_shreg (
        .ijtag_tck   (ijtag_tck),
        .ijtag_reset (ijtag_reset),
        .load        (sr_load),
        .load_data   (req_data),
        .shift       (sr_shift),
        .shift_in    (ijtag_so),
        .data        (sr_data)
    );

    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            rd_data <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_DATA_CAP) begin
                cnt <= '0;
            end else if ((state == ST_DATA_SHIFT) && (cnt != CNT_LAST)) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (state == ST_DATA_UPD) begin
                rd_data <= sr_data;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        ijtag_sel = 1'b1;
        ijtag_ce  = 1'b0;
        ijtag_se  = 1'b0;
        ijtag_ue  = 1'b0;
        ijtag_si  = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                ijtag_sel = 1'b0;
                if (req_valid) state_nxt = ST_OPEN_CAP;
            end
            ST_OPEN_CAP: begin
                ijtag_ce  = 1'b1;
                state_nxt = ST_OPEN_SHIFT;
            end
            ST_OPEN_SHIFT: begin
                ijtag_se  = 1'b1;
                ijtag_si  = 1'b1;
                state_nxt = ST_OPEN_UPD;
            end
            ST_OPEN_UPD: begin
                ijtag_ue  = 1'b1;
                state_nxt = ST_OPEN_WAIT;
            end
            ST_OPEN_WAIT: state_nxt = ST_DATA_CAP;
            ST_DATA_CAP: begin
                ijtag_ce  = 1'b1;
                state_nxt = ST_DATA_SHIFT;
            end
            ST_DATA_SHIFT: begin
                ijtag_se = 1'b1;
                ijtag_si = (cnt == '0) ? 1'b0 : sr_data[DATA_W-1];
                if (cnt == CNT_LAST) state_nxt = ST_DATA_UPD;
            end
            ST_DATA_UPD: begin
                ijtag_ue  = 1'b1;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                ijtag_sel = 1'b0;
                state_nxt = ST_IDLE;
            end
            default: begin
                ijtag_sel = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
